// File: rtl/booth_multiplier.sv
// Signed N x N radix-4 Booth multiplier: Booth recoding, Dadda reduction, one final adder, registered result.
// Define BOOTH_MUL_PIPE_EN to register the two Dadda rows before the final adder (latency 2 instead of 1).
module booth_multiplier #(
  parameter int N = 11
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic [2*N-1:0] result
);

  localparam int M      = (N + 2) / 2;  // Booth digits: ceil((N+1)/2)
  localparam int W      = 2 * N;
  localparam int MAXH   = M + 3;
  localparam int NSTAGE = 9;

  // Each partial-product sign s is rewritten as ~s at its sign column minus that column's weight;
  // all of those negative weights fold into this single row of constant ones.
  function automatic logic [W-1:0] se_const();
    logic [W-1:0] c;
    c = '0;
    for (int i = 0; i < M; i++) begin
      if (N + 2 * i < W) c = c - (W'(1) << (N + 2 * i));
    end
    return c;
  endfunction

  localparam logic [W-1:0] SE_CONST = se_const();

  function automatic int dadda_d(input int j);
    int d;
    d = 2;
    for (int k = 0; k < j; k++) d = (d * 3) / 2;
    return d;
  endfunction

  logic [2*M:0] b_ext;
  logic [N:0]   pp     [M];
  logic         pp_neg [M];
  logic [W-1:0] row_s;
  logic [W-1:0] row_c;

  assign b_ext = {{(2 * M - N){B[N-1]}}, B, 1'b0};

  for (genvar i = 0; i < M; i++) begin : g_booth
    logic [2:0] t;
    logic       one;
    logic       two;
    logic [N:0] mag;
    assign t         = b_ext[2*i +: 3];
    assign one       = t[0] ^ t[1];
    assign two       = (t[2] & ~t[1] & ~t[0]) | (~t[2] & t[1] & t[0]);
    assign pp_neg[i] = t[2] & ~(t[1] & t[0]);
    assign mag       = one ? {A[N-1], A} : (two ? {A, 1'b0} : '0);
    // Negation is the inversion here plus pp_neg[i] injected as an extra bit in the tree.
    assign pp[i]     = mag ^ {(N + 1){pp_neg[i]}};
  end

  // Column-wise Dadda reduction; loops unroll into a fixed network of full and half adders.
  always_comb begin : dadda
    logic [MAXH-1:0] col  [W];
    logic [MAXH-1:0] nxt  [W];
    int              cnt  [W];
    int              ncnt [W];
    int              hmax;
    int              d;
    int              ex;
    int              nfa;
    int              nha;
    int              used;
    logic            x0;
    logic            x1;
    logic            x2;

    row_s = '0;
    row_c = '0;
    hmax  = 0;
    d     = 0;
    ex    = 0;
    nfa   = 0;
    nha   = 0;
    used  = 0;
    x0    = 1'b0;
    x1    = 1'b0;
    x2    = 1'b0;
    for (int c = 0; c < W; c++) begin
      col[c]  = '0;
      nxt[c]  = '0;
      cnt[c]  = 0;
      ncnt[c] = 0;
    end

    for (int i = 0; i < M; i++) begin
      for (int j = 0; j <= N; j++) begin
        if (2 * i + j < W) begin
          col[2*i+j][cnt[2*i+j]] = (j == N) ? ~pp[i][N] : pp[i][j];
          cnt[2*i+j] = cnt[2*i+j] + 1;
        end
      end
      col[2*i][cnt[2*i]] = pp_neg[i];
      cnt[2*i] = cnt[2*i] + 1;
    end
    for (int c = 0; c < W; c++) begin
      if (SE_CONST[c]) begin
        col[c][cnt[c]] = 1'b1;
        cnt[c] = cnt[c] + 1;
      end
    end

    for (int s = NSTAGE - 1; s >= 0; s--) begin
      d    = dadda_d(s);
      hmax = 0;
      for (int c = 0; c < W; c++) begin
        if (cnt[c] > hmax) hmax = cnt[c];
      end
      if (hmax > d) begin
        for (int c = 0; c < W; c++) begin
          nxt[c]  = '0;
          ncnt[c] = 0;
        end
        for (int c = 0; c < W; c++) begin
          // Carries already pushed into this column this stage count toward its target height.
          ex   = cnt[c] + ncnt[c] - d;
          nfa  = (ex > 0) ? ex / 2 : 0;
          nha  = (ex > 0) ? ex % 2 : 0;
          used = 0;
          for (int k = 0; k < MAXH; k++) begin
            if (k < nfa) begin
              x0 = col[c][used];
              x1 = col[c][used+1];
              x2 = col[c][used+2];
              used = used + 3;
              nxt[c][ncnt[c]] = x0 ^ x1 ^ x2;
              ncnt[c] = ncnt[c] + 1;
              if (c + 1 < W) begin
                nxt[c+1][ncnt[c+1]] = (x0 & x1) | (x0 & x2) | (x1 & x2);
                ncnt[c+1] = ncnt[c+1] + 1;
              end
            end
          end
          if (nha == 1) begin
            x0 = col[c][used];
            x1 = col[c][used+1];
            used = used + 2;
            nxt[c][ncnt[c]] = x0 ^ x1;
            ncnt[c] = ncnt[c] + 1;
            if (c + 1 < W) begin
              nxt[c+1][ncnt[c+1]] = x0 & x1;
              ncnt[c+1] = ncnt[c+1] + 1;
            end
          end
          for (int k = 0; k < MAXH; k++) begin
            if (k >= used && k < cnt[c]) begin
              nxt[c][ncnt[c]] = col[c][k];
              ncnt[c] = ncnt[c] + 1;
            end
          end
        end
        col = nxt;
        cnt = ncnt;
      end
    end

    for (int c = 0; c < W; c++) begin
      row_s[c] = col[c][0];
      row_c[c] = col[c][1];
    end
  end

`ifdef BOOTH_MUL_PIPE_EN
  logic [W-1:0] row_s_q;
  logic [W-1:0] row_c_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_s_q <= '0;
      row_c_q <= '0;
      result  <= '0;
    end else begin
      row_s_q <= row_s;
      row_c_q <= row_c;
      result  <= row_s_q + row_c_q;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
    end else begin
      result <= row_s + row_c;
    end
  end
`endif

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier: N=11 directed/random vectors plus an exhaustive N=6 sweep.
// Expected products come from a signed reference multiply and are matched in order through queues.
module tb_booth_multiplier;

`ifdef BOOTH_MUL_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst;
  logic [10:0] a_11;
  logic [10:0] b_11;
  logic [21:0] res_11;
  logic [5:0]  a_6;
  logic [5:0]  b_6;
  logic [11:0] res_6;

  int n_checks;
  int n_errors;

  logic [21:0] exp11_q[$];
  logic [11:0] exp6_q[$];

  booth_multiplier #(.N(11)) dut11 (
    .clk    (clk),
    .rst    (rst),
    .A      (a_11),
    .B      (b_11),
    .result (res_11)
  );

  booth_multiplier #(.N(6)) dut6 (
    .clk    (clk),
    .rst    (rst),
    .A      (a_6),
    .B      (b_6),
    .result (res_6)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // In-flight operands are dropped by reset; with the extra stage the first post-reset edge yields 0.
  task automatic flush();
    exp11_q.delete();
    exp6_q.delete();
    for (int i = 0; i < LAT - 1; i++) begin
      exp11_q.push_back('0);
      exp6_q.push_back('0);
    end
  endtask

  // Driver: apply one operand pair to each DUT for one clock and score whatever has matured.
  task automatic cycle(input logic [10:0] a11, input logic [10:0] b11,
                       input logic [5:0] a6, input logic [5:0] b6, input string tag);
    longint p11;
    longint p6;
    a_11 = a11;
    b_11 = b11;
    a_6  = a6;
    b_6  = b6;
    p11 = longint'($signed(a11)) * longint'($signed(b11));
    p6  = longint'($signed(a6)) * longint'($signed(b6));
    exp11_q.push_back(p11[21:0]);
    exp6_q.push_back(p6[11:0]);
    @(posedge clk);
    #1;
    if (exp11_q.size() == LAT) check({tag, "_n11"}, 64'(res_11), 64'(exp11_q.pop_front()));
    if (exp6_q.size() == LAT) check({tag, "_n6"}, 64'(res_6), 64'(exp6_q.pop_front()));
  endtask

  logic [10:0] dir_a [16];
  logic [10:0] dir_b [16];

  initial begin
    n_checks = 0;
    n_errors = 0;
    dir_a = '{11'd0, 11'd1, 11'd4, 11'd41, 11'd3, 11'd13, 11'd109, 11'd63,
              11'h400, 11'h3FF, 11'h7FF, 11'h400, 11'h7FF, 11'd0, 11'd1, 11'h555};
    dir_b = '{11'd0, 11'd1, 11'd12, 11'd18, 11'd205, 11'd12, 11'd3, 11'd63,
              11'h400, 11'h400, 11'h7FF, 11'h7FF, 11'd1, 11'h3FF, 11'h400, 11'd0};

    rst  = 1'b1;
    a_11 = 11'h2AB;
    b_11 = 11'h155;
    a_6  = 6'h2B;
    b_6  = 6'h15;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold_n11", 64'(res_11), 64'd0);
    check("reset_hold_n6", 64'(res_6), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    flush();

    for (int i = 0; i < 16; i++) begin
      cycle(dir_a[i], dir_b[i], 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), "directed");
    end

    for (int i = 0; i < 20; i++) begin
      cycle(11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047)),
            6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), "b2b");
    end

    // Asynchronous reset mid-stream, well away from any clock edge.
    rst = 1'b1;
    #1;
    check("async_rst_n11", 64'(res_11), 64'd0);
    check("async_rst_n6", 64'(res_6), 64'd0);
    @(posedge clk);
    #1;
    check("rst_edge_n11", 64'(res_11), 64'd0);
    check("rst_edge_n6", 64'(res_6), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    flush();
    cycle(11'd0, 11'd0, 6'd0, 6'd0, "post_rst_zero");
    cycle(11'h400, 11'h400, 6'h20, 6'h20, "post_rst_ext");
    for (int i = 0; i < 12; i++) begin
      cycle(11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047)),
            6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), "post_rst_b2b");
    end

    for (int a = 0; a < 64; a++) begin
      for (int b = 0; b < 64; b++) begin
        cycle(11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047)), 6'(a), 6'(b), "exh");
      end
    end
    for (int i = 0; i < LAT; i++) begin
      cycle(11'd0, 11'd0, 6'd0, 6'd0, "drain");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
